// File: rtl/key_reader_pkg.sv
// Shared constants for the DE2 pushbutton reader: FSM state encodings and
// default timing derived from the 50 MHz board clock.
package key_reader_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;  // 20 ms at 50 MHz
  localparam int DEFAULT_TICK_CYCLES     = 50000;    // 1 ms at 50 MHz

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous board input; the reset value lets
// active-low buttons and switches come out of reset in their idle state.
module sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_reader.sv
// Debounced reader for one active-low DE2 KEY: clean level, press/release
// pulses, hold duration in ticks and a one-shot long-press pulse.
module key_reader
  import key_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TICK_CYCLES     = DEFAULT_TICK_CYCLES,
  parameter int DUR_W           = 16,
  parameter int LONG_TICKS      = 1000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             key_n,
  output logic             pressed,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_press,
  output logic [DUR_W-1:0] duration,
  output logic             duration_valid
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TICK_W = $clog2(TICK_CYCLES) + 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
  localparam logic [DUR_W-1:0]  LONG_AT   = DUR_W'(LONG_TICKS);

  logic              key_s;
  logic [1:0]        state;
  logic [DEB_W-1:0]  deb_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [DUR_W-1:0]  dur_cnt;
  logic              long_done;
  logic              timing;

  sync2 #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk(CLOCK_50),
    .rst(RESET),
    .d  (key_n),
    .q  (key_s)
  );

  // Hold time keeps running through release bounces and the release window.
  assign timing = (state == PRESSED) || (state == RELEASE_WAIT);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state          <= IDLE;
      deb_cnt        <= '0;
      tick_cnt       <= '0;
      dur_cnt        <= '0;
      long_done      <= 1'b0;
      pressed        <= 1'b0;
      press_pulse    <= 1'b0;
      release_pulse  <= 1'b0;
      long_press     <= 1'b0;
      duration       <= '0;
      duration_valid <= 1'b0;
    end else begin
      press_pulse    <= 1'b0;
      release_pulse  <= 1'b0;
      long_press     <= 1'b0;
      duration_valid <= 1'b0;

      if (timing) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
          if (dur_cnt != DUR_MAX) begin
            dur_cnt <= dur_cnt + 1'b1;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
        if ((dur_cnt == LONG_AT) && !long_done) begin
          long_press <= 1'b1;
          long_done  <= 1'b1;
        end
      end

      // Press acceptance restarts hold timing; later assignments win.
      case (state)
        IDLE: begin
          if (!key_s) begin
            state   <= PRESS_WAIT;
            deb_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (key_s) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            pressed     <= 1'b1;
            tick_cnt    <= '0;
            dur_cnt     <= '0;
            long_done   <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (key_s) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!key_s) begin
            state <= PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state          <= IDLE;
            release_pulse  <= 1'b1;
            duration_valid <= 1'b1;
            duration       <= dur_cnt;
            pressed        <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_reader.sv
// Directed bench for key_reader with short timing (debounce 4, tick 2,
// 4-bit duration, long press at 5 ticks).
module tb_key_reader;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic       key_n    = 1'b1;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press;
  logic [3:0] duration;
  logic       duration_valid;

  int compared   = 0;
  int mismatched = 0;
  int long_count = 0;

  key_reader #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (2),
    .DUR_W          (4),
    .LONG_TICKS     (5)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .RESET         (RESET),
    .key_n         (key_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .duration      (duration),
    .duration_valid(duration_valid)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic stepEdge();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic checkQuiet(input string tag, input logic [3:0] exp_dur);
    checkOutput({tag, ".pressed"}, pressed, 0);
    checkOutput({tag, ".press_pulse"}, press_pulse, 0);
    checkOutput({tag, ".release_pulse"}, release_pulse, 0);
    checkOutput({tag, ".long_press"}, long_press, 0);
    checkOutput({tag, ".duration_valid"}, duration_valid, 0);
    checkOutput({tag, ".duration"}, duration, exp_dur);
  endtask

  // Hold key_n at a level for a number of edges; nothing may be accepted.
  task automatic applyStimulus(input logic level, input int cycles,
                               input logic [3:0] exp_dur);
    key_n = level;
    for (int i = 0; i < cycles; i++) begin
      stepEdge();
      checkQuiet("bounce", exp_dur);
    end
  endtask

  // Press acceptance is expected on the 7th edge after key_n falls.
  task automatic pressAndCheck(input string tag);
    key_n = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      stepEdge();
      checkOutput({tag, ".press_pulse"}, press_pulse, (n == 7));
      checkOutput({tag, ".pressed"}, pressed, (n == 7));
      checkOutput({tag, ".release_pulse"}, release_pulse, 0);
    end
  endtask

  // Hold for release_edge-7 edges past acceptance, then check pulse timing.
  task automatic holdAndRelease(input string tag, input int rise_after,
                                input int release_edge, input logic [3:0] exp_dur);
    long_count = 0;
    for (int k = 1; k <= release_edge + 3; k++) begin
      stepEdge();
      if (long_press) long_count++;
      checkOutput({tag, ".long_press"}, long_press, (k == 11));
      checkOutput({tag, ".release_pulse"}, release_pulse, (k == release_edge));
      checkOutput({tag, ".duration_valid"}, duration_valid, (k == release_edge));
      checkOutput({tag, ".pressed"}, pressed, (k < release_edge));
      checkOutput({tag, ".press_pulse"}, press_pulse, 0);
      if (k >= release_edge) checkOutput({tag, ".duration"}, duration, exp_dur);
      if (k == rise_after) key_n = 1'b1;
    end
    checkOutput({tag, ".long_count"}, long_count, 1);
  endtask

  initial begin
    RESET = 1'b1;
    key_n = 1'b1;
    repeat (3) stepEdge();
    checkQuiet("in_reset", 4'd0);
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      stepEdge();
      checkQuiet("idle", 4'd0);
    end

    pressAndCheck("clean");
    holdAndRelease("hold", 13, 20, 4'd9);

    applyStimulus(1'b0, 2, 4'd9);
    applyStimulus(1'b1, 3, 4'd9);
    applyStimulus(1'b0, 2, 4'd9);
    applyStimulus(1'b1, 10, 4'd9);

    pressAndCheck("sat");
    holdAndRelease("sat", 60, 67, 4'd15);

    pressAndCheck("pre_rst");
    repeat (3) stepEdge();
    RESET = 1'b1;
    #1;
    checkQuiet("mid_rst", 4'd0);
    repeat (2) begin
      stepEdge();
      checkQuiet("held_rst", 4'd0);
    end
    RESET = 1'b0;
    pressAndCheck("repress");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
